// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int   DATA_BITS_MAX   = 8;
    localparam int   STOP_BITS_MIN   = 1;
    localparam logic PARITY_SEL_EVEN = 1'b0;
    localparam logic PARITY_SEL_ODD  = 1'b1;

    // Zero-padding narrower payloads does not change the XOR reduction.
    function automatic logic calc_parity(input logic [DATA_BITS_MAX-1:0] data, input logic odd);
        return (^data) ^ (odd == PARITY_SEL_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous holding FIFO in front of the serialiser; dout shows the head entry.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     SysClk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge SysClk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit stage: FIFO-buffered bytes serialised LSB-first, one bit per BaudClk period.
//
// state  | meaning
// IDLE   | line high, waiting for a tick with data in the FIFO
// START  | start bit (0) on the line
// DATA   | payload bits, bitcnt selects the current one
// PARITY | parity bit on the line
// STOP   | stop bit(s), stopcnt counts them; may chain straight into START
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          SysClk,
    input  logic                          Rst,
    input  logic                          BaudClk,
    input  logic [DATA_BITS-1:0]          TxData,
    input  logic                          TxValid,
    output logic                          TxReady,
    output logic                          Tx,
    output logic                          TxBusy,
    output logic [$clog2(FIFO_DEPTH):0]   FifoCount
);
    localparam int             BW        = $clog2(DATA_BITS);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic           LAST_STOP = (STOP_BITS > STOP_BITS_MIN);

    tx_state_t            state;
    logic                 baud_q;
    logic                 baud_tick;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic [BW-1:0]        bitcnt;
    logic                 stopcnt;
    logic                 last_stop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 load_parity;

    assign baud_tick   = BaudClk & ~baud_q;
    assign last_stop   = (stopcnt == LAST_STOP);
    assign TxReady     = ~fifo_full;
    assign load_parity = calc_parity(DATA_BITS_MAX'(fifo_dout), 1'(PARITY_ODD));
    assign fifo_pop    = baud_tick & ~fifo_empty &
                         ((state == IDLE) | ((state == STOP) & last_stop));

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .SysClk (SysClk),
        .Rst    (Rst),
        .push   (TxValid & TxReady),
        .pop    (fifo_pop),
        .din    (TxData),
        .dout   (fifo_dout),
        .count  (FifoCount),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state      <= IDLE;
            Tx         <= 1'b1;
            TxBusy     <= 1'b0;
            baud_q     <= 1'b0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            bitcnt     <= '0;
            stopcnt    <= 1'b0;
        end else begin
            baud_q <= BaudClk;
            if (baud_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            shreg      <= fifo_dout;
                            parity_bit <= load_parity;
                            Tx         <= 1'b0;
                            TxBusy     <= 1'b1;
                            state      <= START;
                        end else begin
                            Tx <= 1'b1;
                        end
                    end
                    START: begin
                        Tx     <= shreg[0];
                        bitcnt <= '0;
                        state  <= DATA;
                    end
                    DATA: begin
                        if (bitcnt != LAST_BIT) begin
                            shreg  <= shreg >> 1;
                            Tx     <= shreg[1];
                            bitcnt <= bitcnt + 1'b1;
                        end else if (PARITY_EN != 0) begin
                            Tx    <= parity_bit;
                            state <= PARITY;
                        end else begin
                            Tx      <= 1'b1;
                            stopcnt <= 1'b0;
                            state   <= STOP;
                        end
                    end
                    PARITY: begin
                        Tx      <= 1'b1;
                        stopcnt <= 1'b0;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (!last_stop) begin
                            stopcnt <= stopcnt + 1'b1;
                        end else if (!fifo_empty) begin
                            // Next frame starts immediately, no idle bit between frames.
                            shreg      <= fifo_dout;
                            parity_bit <= load_parity;
                            Tx         <= 1'b0;
                            state      <= START;
                        end else begin
                            TxBusy <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                    default: begin
                        Tx     <= 1'b1;
                        TxBusy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
